// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl -- single-outstanding instruction fetch controller.
//
// Issues one instruction-memory request at a time from the current PC, captures
// the returned word, and presents it to decode until decode accepts it. Branch
// redirects override everything else. A request that waits too long for its
// ack, or a redirect to a misaligned target, parks the block in a sticky error
// state.
//
// Parameters
//   RESET_PC         PC loaded on reset
//   MAX_WAIT         REQ cycles without ack before timeout (1..255)
// Ports
//   clk, rst_n       clock, synchronous active-low reset
//   run              fetch enable; 0 parks in IDLE once the current fetch ends
//   imem_req/addr    request to instruction memory (addr = current PC)
//   imem_ack/rdata   memory response; rdata valid when ack=1
//   instr_valid      instruction available to decode
//   instr/instr_pc   captured instruction word and its PC
//   instr_ready      decode accepts instr this cycle
//   redirect/target  taken branch / jump; load new PC
//   fetch_err        sticky error (timeout or misaligned redirect)
// -----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        ERR  = 2'd3
    } state_t;

    // Captured response: instruction word and the PC it was fetched from.
    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } fetch_rsp_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t     state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [7:0]  wait_q, wait_d;
    fetch_rsp_t  rsp_q, rsp_d;

    logic [7:0]  wait_inc;
    logic        target_misaligned;

    assign wait_inc          = wait_q + 8'd1;
    assign target_misaligned = (redirect_target[1:0] != 2'b00);

    // -------------------------------------------------------------------------
    // Next-state logic. A redirect is handled identically in every state: an
    // aligned target reloads the PC and restarts (or parks, if run=0); a
    // misaligned one leaves the PC alone and enters ERR. In ERR a misaligned
    // redirect therefore simply keeps us there.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        wait_d  = wait_q;
        rsp_d   = rsp_q;

        if (redirect) begin
            if (target_misaligned) begin
                state_d = ERR;
            end else begin
                pc_d    = redirect_target;
                wait_d  = 8'd0;
                state_d = run ? REQ : IDLE;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (run) begin
                        state_d = REQ;
                        wait_d  = 8'd0;
                    end
                end

                // run is deliberately ignored here: an issued request is always
                // carried through HOLD before the block can park.
                REQ: begin
                    if (imem_ack) begin
                        rsp_d.word = imem_rdata;
                        rsp_d.pc   = pc_q;
                        state_d    = HOLD;
                        wait_d     = 8'd0;
                    end else begin
                        wait_d = wait_inc;
                        if (wait_inc == MAX_WAIT_C) begin
                            state_d = ERR;
                        end
                    end
                end

                HOLD: begin
                    if (instr_ready) begin
                        pc_d    = pc_q + 32'd4;   // wraps modulo 2^32
                        wait_d  = 8'd0;
                        state_d = run ? REQ : IDLE;
                    end
                end

                ERR: begin
                    // Only an aligned redirect (handled above) or reset leaves.
                end

                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            wait_q  <= 8'd0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            wait_q  <= wait_d;
            rsp_q   <= rsp_d;
        end
    end

    // Outputs are pure state/register decode: no path from imem_ack to
    // imem_req, and REQ/HOLD exclusivity keeps req and valid mutually exclusive.
    assign imem_req    = (state_q == REQ);
    assign instr_valid = (state_q == HOLD);
    assign fetch_err   = (state_q == ERR);
    assign imem_addr   = pc_q;
    assign instr       = rsp_q.word;
    assign instr_pc    = rsp_q.pc;

endmodule
